// File: rtl/s2mm_scheduler.sv
// s2mm_scheduler
//   Sequences one stream-to-memory transfer. A CSR start latches the
//   command, kicks the AXI write master once, and lets the RX stream into
//   the FIFO. Framing (TLAST position) and write-master status are then
//   watched until the transfer completes or fails.
//
// Ports
//   clk, rst              single clock, synchronous active-high reset
//   start_i, dst_addr_i,
//   len_bytes_i,
//   max_beats_i           CSR command, sampled when a start is accepted
//   wr_start_o            1-cycle kick to the write master
//   wr_dst_addr_o,
//   wr_len_bytes_o,
//   wr_max_beats_o        latched command fields for the write master
//   wr_done_i, wr_err_i,
//   wr_err_code_i         write-master status (wr_done_i is a pulse)
//   rx_enable_o           allows the stream RX to push beats
//   push_fire_i, tlast_i  one beat pushed; tlast_i qualifies that beat
//   dma_busy_o, dma_done_o,
//   dma_err_o,
//   dma_err_code_o,
//   dma_err_src_o         transfer status (src 0 = write master, 1 = framing/cmd)
//   dbg_state_o           current FSM state for observation
//
// Handshake note: there is no valid/ready pair here. A beat exists only in
// the cycle push_fire_i is high, and it is counted only while rx_enable_o
// is high in that same cycle; pushes at any other time are discarded.
module s2mm_scheduler #(
    parameter int AW = 32,
    parameter int DW = 64
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start_i,
    input  logic [AW-1:0] dst_addr_i,
    input  logic [31:0]   len_bytes_i,
    input  logic [7:0]    max_beats_i,
    output logic          wr_start_o,
    output logic [AW-1:0] wr_dst_addr_o,
    output logic [31:0]   wr_len_bytes_o,
    output logic [7:0]    wr_max_beats_o,
    input  logic          wr_done_i,
    input  logic          wr_err_i,
    input  logic [1:0]    wr_err_code_i,
    output logic          rx_enable_o,
    input  logic          push_fire_i,
    input  logic          tlast_i,
    output logic          dma_busy_o,
    output logic          dma_done_o,
    output logic          dma_err_o,
    output logic [1:0]    dma_err_code_o,
    output logic          dma_err_src_o,
    output logic [2:0]    dbg_state_o
);

    localparam logic [31:0] BPB = 32'(DW / 8);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_KICK_WR = 3'd1,
        S_RUN     = 3'd2,
        S_DONE    = 3'd3,
        S_ERR     = 3'd4
    } state_t;

    state_t        st_q, st_d;
    logic [AW-1:0] dst_addr_q;
    logic [31:0]   len_bytes_q;
    logic [7:0]    max_beats_q;
    logic [31:0]   beats_total_q;
    logic [31:0]   beats_recv_q;
    logic          wr_done_seen_q;
    logic          err_q, err_d;
    logic [1:0]    err_code_q, err_code_d;
    logic          err_src_q, err_src_d;

    logic start_ok;
    logic push_cnt;
    logic last_beat;

    assign start_ok  = start_i && ((st_q == S_IDLE) || (st_q == S_ERR));
    assign push_cnt  = push_fire_i && rx_enable_o;
    assign last_beat = (beats_recv_q == (beats_total_q - 32'd1));

    // State and error-status register
    always_ff @(posedge clk) begin
        if (rst) begin
            st_q       <= S_IDLE;
            err_q      <= 1'b0;
            err_code_q <= 2'b00;
            err_src_q  <= 1'b0;
        end else begin
            st_q       <= st_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
            err_src_q  <= err_src_d;
        end
    end

    // Next-state and error capture
    always_comb begin
        st_d       = st_q;
        err_d      = err_q;
        err_code_d = err_code_q;
        err_src_d  = err_src_q;
        unique case (st_q)
            S_IDLE, S_ERR: begin
                if (start_ok) begin
                    err_d      = 1'b0;
                    err_code_d = 2'b00;
                    err_src_d  = 1'b0;
                    if (len_bytes_i == 32'd0) begin
                        st_d = S_DONE;
                    end else if ((len_bytes_i % BPB) != 32'd0) begin
                        st_d       = S_ERR;
                        err_d      = 1'b1;
                        err_code_d = 2'b11;
                        err_src_d  = 1'b1;
                    end else begin
                        st_d = S_KICK_WR;
                    end
                end
            end
            S_KICK_WR: st_d = S_RUN;
            S_RUN: begin
                // Write-master error outranks any framing error in the same cycle.
                if (wr_err_i) begin
                    st_d       = S_ERR;
                    err_d      = 1'b1;
                    err_code_d = wr_err_code_i;
                    err_src_d  = 1'b0;
                end else if (push_cnt && tlast_i && !last_beat) begin
                    st_d       = S_ERR;
                    err_d      = 1'b1;
                    err_code_d = 2'b01;
                    err_src_d  = 1'b1;
                end else if (push_cnt && last_beat && !tlast_i) begin
                    st_d       = S_ERR;
                    err_d      = 1'b1;
                    err_code_d = 2'b10;
                    err_src_d  = 1'b1;
                end else if (wr_done_seen_q && (beats_recv_q == beats_total_q)) begin
                    // Uses registered values, so completion lands one edge
                    // after the last of {final push, wr_done_i}.
                    st_d = S_DONE;
                end
            end
            S_DONE:  st_d = S_IDLE;
            default: st_d = S_IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        wr_start_o     = (st_q == S_KICK_WR);
        rx_enable_o    = (st_q == S_RUN) && (beats_recv_q < beats_total_q);
        dma_busy_o     = (st_q != S_IDLE) && (st_q != S_ERR);
        dma_done_o     = (st_q == S_DONE);
        dma_err_o      = err_q;
        dma_err_code_o = err_code_q;
        dma_err_src_o  = err_src_q;
        wr_dst_addr_o  = dst_addr_q;
        wr_len_bytes_o = len_bytes_q;
        wr_max_beats_o = max_beats_q;
        dbg_state_o    = st_q;
    end

    // Command latch and beat bookkeeping
    always_ff @(posedge clk) begin
        if (rst) begin
            dst_addr_q     <= '0;
            len_bytes_q    <= 32'd0;
            max_beats_q    <= 8'd0;
            beats_total_q  <= 32'd0;
            beats_recv_q   <= 32'd0;
            wr_done_seen_q <= 1'b0;
        end else if (start_ok) begin
            dst_addr_q     <= dst_addr_i;
            len_bytes_q    <= len_bytes_i;
            max_beats_q    <= max_beats_i;
            beats_total_q  <= len_bytes_i / BPB;
            beats_recv_q   <= 32'd0;
            wr_done_seen_q <= 1'b0;
        end else if (st_q == S_RUN) begin
            if (push_cnt) begin
                beats_recv_q <= beats_recv_q + 32'd1;
            end
            if (wr_done_i) begin
                wr_done_seen_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_s2mm_scheduler.sv
// Directed bench for s2mm_scheduler (DW=64, 8 bytes per beat).
// Inputs change 1 ns after a rising edge; outputs are checked there too,
// so each check sees the state produced by the edge just taken.
module tb_s2mm_scheduler;

    localparam int AW = 32;
    localparam int DW = 64;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_KICK = 3'd1;
    localparam logic [2:0] S_RUN  = 3'd2;
    localparam logic [2:0] S_DONE = 3'd3;
    localparam logic [2:0] S_ERR  = 3'd4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start_i = 1'b0;
    logic [AW-1:0] dst_addr_i = '0;
    logic [31:0]   len_bytes_i = 32'd0;
    logic [7:0]    max_beats_i = 8'd0;
    logic          wr_start_o;
    logic [AW-1:0] wr_dst_addr_o;
    logic [31:0]   wr_len_bytes_o;
    logic [7:0]    wr_max_beats_o;
    logic          wr_done_i = 1'b0;
    logic          wr_err_i = 1'b0;
    logic [1:0]    wr_err_code_i = 2'b00;
    logic          rx_enable_o;
    logic          push_fire_i = 1'b0;
    logic          tlast_i = 1'b0;
    logic          dma_busy_o;
    logic          dma_done_o;
    logic          dma_err_o;
    logic [1:0]    dma_err_code_o;
    logic          dma_err_src_o;
    logic [2:0]    dbg_state_o;

    int n_assert = 0;
    int n_fail   = 0;

    s2mm_scheduler #(.AW(AW), .DW(DW)) dut (
        .clk            (clk),
        .rst            (rst),
        .start_i        (start_i),
        .dst_addr_i     (dst_addr_i),
        .len_bytes_i    (len_bytes_i),
        .max_beats_i    (max_beats_i),
        .wr_start_o     (wr_start_o),
        .wr_dst_addr_o  (wr_dst_addr_o),
        .wr_len_bytes_o (wr_len_bytes_o),
        .wr_max_beats_o (wr_max_beats_o),
        .wr_done_i      (wr_done_i),
        .wr_err_i       (wr_err_i),
        .wr_err_code_i  (wr_err_code_i),
        .rx_enable_o    (rx_enable_o),
        .push_fire_i    (push_fire_i),
        .tlast_i        (tlast_i),
        .dma_busy_o     (dma_busy_o),
        .dma_done_o     (dma_done_o),
        .dma_err_o      (dma_err_o),
        .dma_err_code_o (dma_err_code_o),
        .dma_err_src_o  (dma_err_src_o),
        .dbg_state_o    (dbg_state_o)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_err(input string tag, input logic e, input logic [1:0] code, input logic src);
        chk({tag, ".err"},  64'(dma_err_o),      64'(e));
        chk({tag, ".code"}, 64'(dma_err_code_o), 64'(code));
        chk({tag, ".src"},  64'(dma_err_src_o),  64'(src));
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".st"},     64'(dbg_state_o),    64'(S_IDLE));
        chk({tag, ".wrst"},   64'(wr_start_o),     64'd0);
        chk({tag, ".rxen"},   64'(rx_enable_o),    64'd0);
        chk({tag, ".busy"},   64'(dma_busy_o),     64'd0);
        chk({tag, ".done"},   64'(dma_done_o),     64'd0);
        chk({tag, ".addr"},   64'(wr_dst_addr_o),  64'd0);
        chk({tag, ".len"},    64'(wr_len_bytes_o), 64'd0);
        chk({tag, ".mb"},     64'(wr_max_beats_o), 64'd0);
        chk_err(tag, 1'b0, 2'b00, 1'b0);
    endtask

    // Issue a start for one cycle; on return the start edge has been taken.
    task automatic cmd(input logic [31:0] addr, input logic [31:0] len, input logic [7:0] mb);
        start_i     = 1'b1;
        dst_addr_i  = addr;
        len_bytes_i = len;
        max_beats_i = mb;
        tick();
        start_i = 1'b0;
    endtask

    // One push beat, then idle the stream.
    task automatic push(input logic last);
        push_fire_i = 1'b1;
        tlast_i     = last;
        tick();
        push_fire_i = 1'b0;
        tlast_i     = 1'b0;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        // Reset, then check every output is zero.
        tick();
        tick();
        rst = 1'b0;
        chk_all_zero("reset");

        // Normal 32-byte transfer: 4 beats.
        cmd(32'h0000_1000, 32'd32, 8'd16);
        chk("norm.kick_st", 64'(dbg_state_o), 64'(S_KICK));
        chk("norm.wrst",    64'(wr_start_o), 64'd1);
        chk("norm.addr",    64'(wr_dst_addr_o), 64'h1000);
        chk("norm.len",     64'(wr_len_bytes_o), 64'd32);
        chk("norm.mb",      64'(wr_max_beats_o), 64'd16);
        chk("norm.busy",    64'(dma_busy_o), 64'd1);
        tick();
        chk("norm.run_st",  64'(dbg_state_o), 64'(S_RUN));
        chk("norm.wrst_off",64'(wr_start_o), 64'd0);
        chk("norm.rxen",    64'(rx_enable_o), 64'd1);
        push(1'b0);
        push(1'b0);
        push(1'b0);
        chk("norm.rxen3",   64'(rx_enable_o), 64'd1);
        push(1'b1);
        chk("norm.rxen_off",64'(rx_enable_o), 64'd0);
        chk("norm.st_wait", 64'(dbg_state_o), 64'(S_RUN));
        // Push while rx disabled is ignored: no framing error.
        push(1'b0);
        chk("norm.ign_push",64'(dbg_state_o), 64'(S_RUN));
        wr_done_i = 1'b1;
        tick();
        wr_done_i = 1'b0;
        chk("norm.st_seen", 64'(dbg_state_o), 64'(S_RUN));
        tick();
        chk("norm.done",    64'(dma_done_o), 64'd1);
        chk("norm.done_bz", 64'(dma_busy_o), 64'd1);
        tick();
        chk("norm.done_off",64'(dma_done_o), 64'd0);
        chk("norm.idle",    64'(dbg_state_o), 64'(S_IDLE));
        chk_err("norm", 1'b0, 2'b00, 1'b0);

        // Zero length: DONE right after start, no kick.
        cmd(32'h0000_2000, 32'd0, 8'd4);
        chk("zero.done",    64'(dma_done_o), 64'd1);
        chk("zero.wrst",    64'(wr_start_o), 64'd0);
        tick();
        chk("zero.idle",    64'(dbg_state_o), 64'(S_IDLE));
        chk("zero.wrst2",   64'(wr_start_o), 64'd0);

        // Early TLAST on push 2.
        cmd(32'h0000_3000, 32'd32, 8'd8);
        tick();
        push(1'b0);
        push(1'b1);
        chk("early.st",     64'(dbg_state_o), 64'(S_ERR));
        chk_err("early", 1'b1, 2'b01, 1'b1);
        chk("early.busy",   64'(dma_busy_o), 64'd0);
        tick();
        tick();
        chk_err("early.sticky", 1'b1, 2'b01, 1'b1);

        // Restart from ERR; missing TLAST on push 4.
        cmd(32'h0000_4000, 32'd32, 8'd8);
        chk("miss.kick",    64'(wr_start_o), 64'd1);
        chk_err("miss.clr", 1'b0, 2'b00, 1'b0);
        tick();
        push(1'b0);
        push(1'b0);
        push(1'b0);
        push(1'b0);
        chk("miss.st",      64'(dbg_state_o), 64'(S_ERR));
        chk_err("miss", 1'b1, 2'b10, 1'b1);

        // Unaligned length.
        cmd(32'h0000_5000, 32'd12, 8'd8);
        chk("unal.st",      64'(dbg_state_o), 64'(S_ERR));
        chk("unal.wrst",    64'(wr_start_o), 64'd0);
        chk_err("unal", 1'b1, 2'b11, 1'b1);
        tick();
        chk("unal.wrst2",   64'(wr_start_o), 64'd0);

        // Write error coincident with an early TLAST: write error wins.
        cmd(32'h0000_6000, 32'd32, 8'd8);
        tick();
        push(1'b0);
        wr_err_i      = 1'b1;
        wr_err_code_i = 2'b10;
        push(1'b1);
        wr_err_i      = 1'b0;
        wr_err_code_i = 2'b00;
        chk("werr.st",      64'(dbg_state_o), 64'(S_ERR));
        chk_err("werr", 1'b1, 2'b10, 1'b0);

        // New 8-byte start clears the error and completes.
        cmd(32'h0000_7000, 32'd8, 8'd1);
        chk_err("len8.clr", 1'b0, 2'b00, 1'b0);
        tick();
        push(1'b1);
        chk("len8.rxen",    64'(rx_enable_o), 64'd0);
        wr_done_i = 1'b1;
        tick();
        wr_done_i = 1'b0;
        tick();
        chk("len8.done",    64'(dma_done_o), 64'd1);
        tick();
        chk("len8.idle",    64'(dbg_state_o), 64'(S_IDLE));

        // wr_done before the final push; a start during RUN is ignored.
        cmd(32'h0000_8000, 32'd32, 8'd8);
        tick();
        push(1'b0);
        start_i     = 1'b1;
        dst_addr_i  = 32'hDEAD_0000;
        len_bytes_i = 32'd0;
        push(1'b0);
        start_i = 1'b0;
        chk("ign.st",       64'(dbg_state_o), 64'(S_RUN));
        chk("ign.addr",     64'(wr_dst_addr_o), 64'h8000);
        chk("ign.len",      64'(wr_len_bytes_o), 64'd32);
        push(1'b0);
        wr_done_i = 1'b1;
        tick();
        wr_done_i = 1'b0;
        chk("pre.st",       64'(dbg_state_o), 64'(S_RUN));
        push(1'b1);
        chk("pre.st2",      64'(dbg_state_o), 64'(S_RUN));
        tick();
        chk("pre.done",     64'(dma_done_o), 64'd1);
        tick();

        // wr_done coincident with the final push.
        cmd(32'h0000_9000, 32'd32, 8'd8);
        tick();
        push(1'b0);
        push(1'b0);
        push(1'b0);
        wr_done_i = 1'b1;
        push(1'b1);
        wr_done_i = 1'b0;
        chk("coin.st",      64'(dbg_state_o), 64'(S_RUN));
        tick();
        chk("coin.done",    64'(dma_done_o), 64'd1);
        tick();
        chk("coin.idle",    64'(dbg_state_o), 64'(S_IDLE));

        // Reset mid-RUN after 2 of 4 pushes.
        cmd(32'h0000_A000, 32'd32, 8'd8);
        tick();
        push(1'b0);
        push(1'b0);
        chk("mid.rxen",     64'(rx_enable_o), 64'd1);
        rst = 1'b1;
        tick();
        chk_all_zero("midrst");
        rst = 1'b0;
        tick();
        chk("mid.idle",     64'(dbg_state_o), 64'(S_IDLE));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
